uart_wb_bridge: RTL and testbench
=================================

// Module: uart_wb_bridge
// PURPOSE
//  Host-debug master that sits upstream of the on-chip dual-port RAM's Wishbone port.
//  - Parses a framed byte stream from the UART receiver into single 32-bit Wishbone
//    read/write cycles (pipelined WB, one outstanding transfer).
//  - Returns the results as a byte stream to the UART transmitter.
// PARAMETERS
//  BYTE_TIMEOUT  100000  idle cycles allowed between bytes of one command before it is abandoned
//  ACK_TIMEOUT   1024    cycles to wait for i_wb_ack after the request is accepted
// PORTS
//  clk         in   1   system clock
//  resetn      in   1   reset, synchronous, active-low
//  rx_valid    in   1   one-cycle strobe: rx_data holds a received byte
//  rx_data     in   8   received byte
//  tx_valid    out  1   response byte valid
//  tx_data     out  8   response byte
//  tx_ready    in   1   transmitter accepts tx_data this cycle
//  o_wb_cyc    out  1   WB cycle
//  o_wb_stb    out  1   WB strobe
//  o_wb_we     out  1   WB write enable
//  o_wb_addr   out  32  WB byte address
//  o_wb_data   out  32  WB write data
//  o_wb_sel    out  4   WB byte select; always 4'hF during a transfer
//  i_wb_stall  in   1   WB stall
//  i_wb_ack    in   1   WB acknowledge
//  i_wb_data   in   32  WB read data, valid with i_wb_ack
//  busy        out  1   high in every state except IDLE
//  rx_drop     out  1   one-cycle pulse: rx byte arrived while not in IDLE/ADDR/DATA, discarded
// BEHAVIOUR
//  Frames (multi-byte fields MSB first):
//    'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0  -> reply 'K'(0x4B)
//    'R'(0x52) A3 A2 A1 A0              -> reply D3 D2 D1 D0
//  Reset and outputs:
//  - Reset: all outputs 0, state IDLE, counters 0.
//  - All outputs are registered.
//  FSM:
//  - IDLE: on 'W'/'R', latch we and go to ADDR. Any other byte is silently ignored.
//  - ADDR: collect 4 bytes into the address, then go to DATA (write) or WB_REQ (read).
//  - DATA: collect 4 bytes into the write data, then go to WB_REQ.
//  - WB_REQ: cyc=stb=1 and we/addr/data/sel valid. Hold while i_wb_stall=1.
//    When stall=0 the request is accepted: next cycle stb=0, we=0, go to WB_WAIT.
//    Only one stb-high cycle is accepted per transfer.
//  - WB_WAIT: cyc=1 until i_wb_ack, then cyc=0.
//    Read: capture i_wb_data on the ack cycle.
//    Go to RESP with 4 bytes (read) or 1 byte 'K' (write).
//    If an ack arrives in the same cycle the request is accepted, it is honoured.
//  - ACK timeout: no ack within ACK_TIMEOUT cycles -> drop cyc and reply 'E'(0x45), 1 byte.
//  - RESP: tx_valid=1 with tx_data stable until tx_ready. Then advance to the next byte.
//    After the last byte, tx_valid=0 next cycle and go to IDLE.
//  Latency:
//  - Last frame byte at cycle N -> cyc/stb high at N+1.
//  - With a 1-cycle-ack slave (stall=0): ack at N+2, first tx_valid at N+3.
//  Boundary conditions:
//  - Byte timeout: in ADDR/DATA, BYTE_TIMEOUT cycles with no rx_valid -> IDLE, no reply.
//    The counter restarts on every byte.
//  - rx_valid in WB_REQ/WB_WAIT/RESP: byte discarded, rx_drop pulses; no backpressure on rx.
//  - Address wrap: the 32-bit address is passed unmodified. The slave decodes low bits.
//  - resetn low mid-transfer: cyc/stb drop next edge and the frame is lost.
// CONFIGURATION
//  UART_WB_AUTOINC_EN defined:
//  - Every completed (acked) transfer does addr += 4 (32-bit wrap).
//  - Extra commands reuse the held address:
//      'w'(0x77) D3..D0 -> write, reply 'K'
//      'r'(0x72)        -> read, goes directly to WB_REQ
//  - A timed-out transfer does not increment the address.
//  UART_WB_AUTOINC_EN undefined:
//  - 'w'/'r' are ignored in IDLE like any unknown byte.
//  - The address register holds its last loaded value.
// TESTING
//  1. Write: 57 00 00 00 10 DE AD BE EF
//     -> one stb cycle, we=1, addr=0x10, data=DEADBEEF, sel=F; reply 4B.
//  2. Read: 52 00 00 00 10 after test 1 -> reply DE AD BE EF.
//     Check cyc/stb at N+1 and tx_valid at N+3 with the single-cycle-ack RAM.
//  3. Stall/backpressure: hold i_wb_stall=1 for 5 cycles -> stb held 5 cycles, exactly one accept.
//     Hold tx_ready=0 for 10 cycles -> tx_data stable, no byte lost.
//  4. Timeouts: send 52 00 then idle BYTE_TIMEOUT -> busy=0, no reply.
//     Slave never acks -> reply 45 after ACK_TIMEOUT and cyc=0.
//  5. Junk/overrun: 0x00 0xFF in IDLE -> ignored.
//     rx byte during RESP -> rx_drop pulse; reply unchanged.
//  6. AUTOINC_EN: 57 00 00 00 20 11111111, then 77 22222222, then 52 00 00 00 24
//     -> 22222222; then 72 -> reads addr 0x28.
//     Without the macro, the 77 frame produces no WB cycle.

Source files
------------

// File: rtl/uart_wb_bridge_if.sv
// uart_wb_bridge_if: pipelined Wishbone bus between the UART debug bridge (master) and its slave
interface uart_wb_bridge_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic [31:0] rdata;
  modport master (output cyc, stb, we, addr, wdata, sel, input stall, ack, rdata);
  modport slave (input cyc, stb, we, addr, wdata, sel, output stall, ack, rdata);
endinterface

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART byte frames to single Wishbone transfers; UART_WB_AUTOINC_EN adds address auto-increment and 'w'/'r'
module uart_wb_bridge #(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       rx_drop,
  uart_wb_bridge_if.master wb
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WB_REQ, WB_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic        wr_q, wr_d, cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic        tx_valid_q, tx_valid_d, busy_q, busy_d, drop_q, drop_d;
  logic [31:0] addr_q, addr_d, dat_q, dat_d, tmo_q, tmo_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req, acked, byte_to, ack_to;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      tmo_q      <= '0;
      sel_q      <= '0;
      tx_data_q  <= '0;
      rbuf_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      rbuf_q     <= rbuf_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    tx_valid_d = tx_valid_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    rbuf_d     = rbuf_q;
    cnt_d      = cnt_q;
    req        = 1'b0;
    acked      = 1'b0;
    byte_to    = tmo_q == 32'(BYTE_TIMEOUT - 1);
    ack_to     = tmo_q == 32'(ACK_TIMEOUT - 1);
    drop_d     = rx_valid && (state_q inside {WB_REQ, WB_WAIT, RESP});
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          wr_d    = rx_data == 8'h57;
          state_d = ADDR;
          cnt_d   = '0;
          tmo_d   = '0;
        end
`ifdef UART_WB_AUTOINC_EN
        else if (rx_data == 8'h77) begin
          wr_d    = 1'b1;
          state_d = DATA;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (rx_data == 8'h72) begin
          wr_d = 1'b0;
          req  = 1'b1;
        end
`endif
      end
      ADDR: if (rx_valid) begin
        addr_d  = {addr_q[23:0], rx_data};
        tmo_d   = '0;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3 && wr_q) ? DATA : ADDR;
        req     = cnt_q == 2'd3 && !wr_q;
      end else begin
        state_d = byte_to ? IDLE : ADDR;
        tmo_d   = tmo_q + 32'd1;
      end
      DATA: if (rx_valid) begin
        dat_d = {dat_q[23:0], rx_data};
        tmo_d = '0;
        cnt_d = cnt_q + 2'd1;
        req   = cnt_q == 2'd3;
      end else begin
        state_d = byte_to ? IDLE : DATA;
        tmo_d   = tmo_q + 32'd1;
      end
      WB_REQ: if (!wb.stall) begin
        stb_d   = 1'b0;
        we_d    = 1'b0;
        tmo_d   = '0;
        state_d = WB_WAIT;
        acked   = wb.ack;
      end
      WB_WAIT: if (wb.ack) begin
        acked = 1'b1;
      end else if (ack_to) begin
        cyc_d      = 1'b0;
        sel_d      = '0;
        state_d    = RESP;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h45;
        cnt_d      = '0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
      RESP: if (tx_ready) begin
        tx_valid_d = cnt_q != 2'd0;
        state_d    = cnt_q == 2'd0 ? IDLE : RESP;
        tx_data_d  = cnt_q == 2'd0 ? tx_data_q : rbuf_q[23:16];
        rbuf_d     = {rbuf_q[15:0], 8'h00};
        cnt_d      = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
    // An ack on the accept cycle completes the transfer without visiting WB_WAIT
    if (acked) begin
      cyc_d      = 1'b0;
      sel_d      = '0;
      state_d    = RESP;
      tx_valid_d = 1'b1;
      tx_data_d  = wr_q ? 8'h4B : wb.rdata[31:24];
      rbuf_d     = wb.rdata[23:0];
      cnt_d      = wr_q ? 2'd0 : 2'd3;
`ifdef UART_WB_AUTOINC_EN
      addr_d     = addr_q + 32'd4;
`endif
    end
    if (req) begin
      state_d = WB_REQ;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = wr_d;
      sel_d   = 4'hF;
    end
    busy_d = state_d != IDLE;
  end
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign rx_drop  = drop_q;
  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = we_q;
  assign wb.addr  = addr_q;
  assign wb.wdata = dat_q;
  assign wb.sel   = sel_q;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: directed vector table plus hand-timed corner sequences for uart_wb_bridge
module tb_uart_wb_bridge;
  localparam int BT = 40;
  localparam int AT = 30;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic tx_valid, tx_ready = 1'b1, busy, rx_drop;
  logic [7:0] tx_data;
  uart_wb_bridge_if wb ();
  uart_wb_bridge #(.BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .rx_drop(rx_drop), .wb(wb)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, accepts = 0, drops = 0;
  bit no_ack = 1'b0;
  logic acc_we;
  logic [31:0] acc_addr, acc_data;
  logic [3:0] acc_sel;
  logic [31:0] mem [logic [31:0]];
  logic [7:0] rxq [$];
  initial begin
    wb.stall = 1'b0;
    wb.ack   = 1'b0;
    wb.rdata = '0;
  end
  always @(posedge clk) begin
    wb.ack <= 1'b0;
    if (wb.cyc && wb.stb && !wb.stall) begin
      accepts  <= accepts + 1;
      acc_we   <= wb.we;
      acc_addr <= wb.addr;
      acc_data <= wb.wdata;
      acc_sel  <= wb.sel;
      if (!no_ack) begin
        wb.ack <= 1'b1;
        if (wb.we) mem[wb.addr] = wb.wdata;
        else wb.rdata <= mem.exists(wb.addr) ? mem[wb.addr] : 32'h0;
      end
    end
    if (tx_valid && tx_ready) rxq.push_back(tx_data);
    if (rx_drop) drops <= drops + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input bit has_a, input bit has_d);
    send_byte(cmd);
    if (has_a) for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (has_d) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask
  task automatic wait_reply(input int n, output logic [31:0] v);
    int k = 0;
    while (rxq.size() < n && k < 3000) begin @(negedge clk); k++; end
    check("reply_len", 32'(rxq.size()), 32'(n));
    v = '0;
    while (rxq.size() > 0) v = {v[23:0], rxq.pop_front()};
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
  endtask
  task automatic wait_txv();
    int k = 0;
    while (!tx_valid && k < 3000) begin @(negedge clk); k++; end
    check("tx_valid_seen", {31'b0, tx_valid}, 32'd1);
  endtask
  typedef struct {bit wr; logic [31:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
  vec_t vt [6];
  initial begin
    logic [31:0] r;
    int acc0, cnt, bad;
    vt[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h4B};
    vt[1] = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 32'h14,       32'h12345678, 32'h4B};
    vt[3] = '{1'b1, 32'hFFFFFFFC, 32'hA5A55A5A, 32'h4B};
    vt[4] = '{1'b0, 32'h14,       32'h0,        32'h12345678};
    vt[5] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'hA5A55A5A};
    tick(3);
    @(negedge clk);
    check("reset_outputs", {22'b0, tx_valid, tx_data, busy, rx_drop},  32'h0);
    check("reset_wb", {wb.cyc, wb.stb, wb.we, wb.sel, wb.addr[24:0]} | {7'b0, wb.wdata[24:0]}, 32'h0);
    resetn = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      acc0 = accepts;
      send_frame(vt[i].wr ? 8'h57 : 8'h52, vt[i].a, vt[i].d, 1'b1, vt[i].wr);
      wait_reply(vt[i].wr ? 1 : 4, r);
      check("vec_reply", r, vt[i].exp);
      check("vec_accepts", 32'(accepts - acc0), 32'd1);
      check("vec_addr", acc_addr, vt[i].a);
      check("vec_we_sel", {27'b0, acc_we, acc_sel}, {27'b0, vt[i].wr, 4'hF});
      if (vt[i].wr) check("vec_wdata", acc_data, vt[i].d);
    end
    // Latency: last byte at N, cyc/stb at N+1, tx_valid at N+3
    send_frame(8'h52, 32'h10, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_n1_cyc_stb", {30'b0, wb.cyc, wb.stb}, 32'h3);
    @(negedge clk);
    check("lat_n2", {29'b0, wb.cyc, wb.stb, tx_valid}, 32'h4);
    @(negedge clk);
    check("lat_n3", {22'b0, wb.cyc, tx_valid, tx_data}, {22'b0, 2'b01, 8'hDE});
    wait_reply(4, r);
    check("lat_reply", r, 32'hDEADBEEF);
    // Stall for 5 cycles and hold off the transmitter for 10
    wb.stall = 1'b1;
    tx_ready = 1'b0;
    acc0 = accepts;
    cnt = 0;
    send_frame(8'h52, 32'h10, 32'h0, 1'b1, 1'b0);
    repeat (5) begin @(negedge clk); cnt += int'(wb.stb); end
    check("stall_stb_cycles", 32'(cnt), 32'd5);
    @(posedge clk);
    #1;
    wb.stall = 1'b0;
    wait_txv();
    bad = 0;
    repeat (10) begin @(negedge clk); if (!tx_valid || tx_data !== 8'hDE) bad++; end
    check("bp_tx_stable", 32'(bad), 32'd0);
    check("stall_one_accept", 32'(accepts - acc0), 32'd1);
    tx_ready = 1'b1;
    wait_reply(4, r);
    check("bp_reply", r, 32'hDEADBEEF);
    // Junk in IDLE is ignored
    acc0 = accepts;
    send_byte(8'h00);
    send_byte(8'hFF);
    tick(5);
    check("junk_ignored", {busy, 31'(accepts - acc0)}, 32'h0);
    check("junk_no_reply", 32'(rxq.size()), 32'd0);
    // Byte during RESP is dropped
    tx_ready = 1'b0;
    acc0 = drops;
    send_frame(8'h52, 32'h14, 32'h0, 1'b1, 1'b0);
    wait_txv();
    send_byte(8'h57);
    @(negedge clk);
    check("drop_pulse", {31'b0, rx_drop}, 32'd1);
    check("drop_tx_data", {24'b0, tx_data}, 32'h12);
    tx_ready = 1'b1;
    wait_reply(4, r);
    check("drop_reply", r, 32'h12345678);
    check("drop_count", 32'(drops - acc0), 32'd1);
    check("drop_idle", {31'b0, busy}, 32'd0);
    // Byte timeout abandons a partial frame
    send_byte(8'h52);
    send_byte(8'h00);
    tick(BT - 5);
    check("bto_still_busy", {31'b0, busy}, 32'd1);
    tick(10);
    check("bto_idle", {31'b0, busy}, 32'd0);
    check("bto_no_reply", 32'(rxq.size()), 32'd0);
    // Each byte restarts the byte timer
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) begin
      tick(BT - 10);
      send_byte(i == 3 ? 8'h10 : 8'h00);
    end
    wait_reply(4, r);
    check("bto_restart_reply", r, 32'hDEADBEEF);
    // Ack timeout
    no_ack = 1'b1;
    send_frame(8'h57, 32'h30, 32'hCAFEF00D, 1'b1, 1'b1);
    wait_reply(1, r);
    check("ato_reply", r, 32'h45);
    check("ato_cyc", {31'b0, wb.cyc}, 32'd0);
    no_ack = 1'b0;
`ifdef UART_WB_AUTOINC_EN
    send_byte(8'h72);
    wait_reply(4, r);
    check("ato_no_inc", acc_addr, 32'h30);
    send_frame(8'h57, 32'h20, 32'h11111111, 1'b1, 1'b1);
    wait_reply(1, r);
    check("ai_w_reply", r, 32'h4B);
    send_frame(8'h77, 32'h0, 32'h22222222, 1'b0, 1'b1);
    wait_reply(1, r);
    check("ai_w2_reply", r, 32'h4B);
    check("ai_w2_addr", acc_addr, 32'h24);
    send_frame(8'h52, 32'h24, 32'h0, 1'b1, 1'b0);
    wait_reply(4, r);
    check("ai_read", r, 32'h22222222);
    send_byte(8'h72);
    wait_reply(4, r);
    check("ai_r_addr", acc_addr, 32'h28);
`else
    acc0 = accepts;
    send_frame(8'h77, 32'h0, 32'h22222222, 1'b0, 1'b1);
    tick(10);
    check("noai_no_cycle", 32'(accepts - acc0), 32'd0);
    check("noai_idle", {31'b0, busy}, 32'd0);
    check("noai_no_reply", 32'(rxq.size()), 32'd0);
`endif
    // Reset mid-transfer
    wb.stall = 1'b1;
    acc0 = accepts;
    send_frame(8'h52, 32'h10, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_pre_stb", {30'b0, wb.cyc, wb.stb}, 32'h3);
    resetn = 1'b0;
    tick(1);
    @(negedge clk);
    check("rst_cyc_stb", {30'b0, wb.cyc, wb.stb}, 32'h0);
    resetn = 1'b1;
    wb.stall = 1'b0;
    tick(5);
    check("rst_idle", {busy, 31'(accepts - acc0)}, 32'h0);
    check("rst_no_reply", 32'(rxq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
